// File: rtl/aes_v2_pkg.sv
// Shared types for the aes_v2 requester arbiter: FSM state encoding
// and the latched operand record (sub, enc, rot, rs1, rs2).
package aes_v2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   typedef struct packed {
      logic        sub;
      logic        enc;
      logic        rot;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } aes_op_t;

   localparam int OP_W = $bits(aes_op_t);

endpackage

// File: rtl/aes_v2_rr_pick.sv
// Combinational round-robin picker.
// Ports: req_valid/ptr in; one-hot gnt, gnt_idx and any-request out.
module aes_v2_rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            any
);

   // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!any && req_valid[j] && (IW'(j) >= ptr)) begin
            any     = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!any && req_valid[j]) begin
            any     = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/aes_v2_arb.sv
// Shares one aes_v2 step unit between NREQ requesters (round-robin).
// Ports: g_clk/g_reset, flush, req_* in, rsp_* out, aes_* unit bus, busy.
module aes_v2_arb
   import aes_v2_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = 2
) (
   input  logic             g_clk,
   input  logic             g_reset,
   input  logic             flush,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [NREQ-1:0]  req_sub,
   input  logic [NREQ-1:0]  req_enc,
   input  logic [NREQ-1:0]  req_rot,
   input  logic [32*NREQ-1:0] req_rs1,
   input  logic [32*NREQ-1:0] req_rs2,
   output logic [NREQ-1:0]  rsp_valid,
   input  logic [NREQ-1:0]  rsp_ready,
   output logic [31:0]      rsp_rd,
   output logic             aes_valid,
   output logic             aes_sub,
   output logic             aes_enc,
   output logic             aes_rot,
   output logic [31:0]      aes_rs1,
   output logic [31:0]      aes_rs2,
   input  logic             aes_ready,
   input  logic [31:0]      aes_rd,
   output logic             busy
);

   state_t           state_q;
   state_t           state_d;
   logic [IW-1:0]    ptr_q;
   logic [IW-1:0]    owner_q;
   aes_op_t          op_q;
   logic [OP_W-1:0]  op_acc;
   logic [31:0]      res_q;
   logic             flushed_q;

   logic [NREQ-1:0]  gnt;
   logic [IW-1:0]    gnt_idx;
   logic             any;
   logic [NREQ-1:0]  own_oh;
   logic             own_rdy;
   logic             accept;
   logic             done;
   logic             drop;

   aes_v2_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .any       (any)
   );

   always_comb begin
      op_acc = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt[j]) begin
            op_acc = {req_sub[j], req_enc[j], req_rot[j],
                      req_rs1[32*j +: 32], req_rs2[32*j +: 32]};
         end
      end
   end

   always_comb begin
      own_oh  = '0;
      own_rdy = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (IW'(j) == owner_q) begin
            own_oh[j] = 1'b1;
            own_rdy   = rsp_ready[j];
         end
      end
   end

   // The unit cannot abort, so a flush seen during ISSUE only
   // drops the result once the unit finishes.
   assign drop = flushed_q | flush;

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      rsp_valid = '0;
      aes_valid = 1'b0;
      accept    = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!flush) begin
               req_ready = gnt;
               if (any) begin
                  accept  = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            aes_valid = 1'b1;
            if (aes_ready) begin
               done    = 1'b1;
               state_d = drop ? ST_IDLE : ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = own_oh;
            if (flush || own_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         op_q      <= '0;
         res_q     <= '0;
         flushed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= aes_op_t'(op_acc);
            owner_q <= gnt_idx;
            ptr_q   <= (gnt_idx == IW'(NREQ-1)) ? '0
                                                : gnt_idx + IW'(1);
         end
         if (done) begin
            flushed_q <= 1'b0;
            if (!drop) begin
               res_q <= aes_rd;
            end
         end else if ((state_q == ST_ISSUE) && flush) begin
            flushed_q <= 1'b1;
         end
      end
   end

   assign aes_sub = op_q.sub;
   assign aes_enc = op_q.enc;
   assign aes_rot = op_q.rot;
   assign aes_rs1 = op_q.rs1;
   assign aes_rs2 = op_q.rs2;
   assign rsp_rd  = res_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_v2_arb.sv
// Bench for aes_v2_arb with a latency-programmable aes_v2 stub.
// Expected responses go into a scoreboard; a monitor pops on handshake.
module tb_aes_v2_arb;

   logic        g_clk = 1'b0;
   logic        g_reset = 1'b1;
   logic        flush = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [1:0]  req_sub = '0;
   logic [1:0]  req_enc = '0;
   logic [1:0]  req_rot = '0;
   logic [63:0] req_rs1 = '0;
   logic [63:0] req_rs2 = '0;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready = 2'b11;
   logic [31:0] rsp_rd;
   logic        aes_valid;
   logic        aes_sub;
   logic        aes_enc;
   logic        aes_rot;
   logic [31:0] aes_rs1;
   logic [31:0] aes_rs2;
   logic        aes_ready;
   logic [31:0] aes_rd;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int stub_delay = 0;
   int stub_cnt;

   typedef struct {
      int          idx;
      logic [31:0] rd;
   } exp_t;
   exp_t sb_q[$];

   aes_v2_arb #(.NREQ(2), .IW(2)) dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sub   (req_sub),
      .req_enc   (req_enc),
      .req_rot   (req_rot),
      .req_rs1   (req_rs1),
      .req_rs2   (req_rs2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rd    (rsp_rd),
      .aes_valid (aes_valid),
      .aes_sub   (aes_sub),
      .aes_enc   (aes_enc),
      .aes_rot   (aes_rot),
      .aes_rs1   (aes_rs1),
      .aes_rs2   (aes_rs2),
      .aes_ready (aes_ready),
      .aes_rd    (aes_rd),
      .busy      (busy)
   );

   always #5 g_clk = ~g_clk;

   // Stub unit: sbox(0x53)=0xED for the sub/enc case, otherwise a
   // simple mix of the operands so every vector has a distinct answer.
   function automatic logic [31:0] stub_f(input logic s, input logic e,
                                          input logic r,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      if (s && e && (a == 32'h53)) return 32'hED;
      return a ^ {b[15:0], b[31:16]} ^ {29'd0, s, e, r};
   endfunction

   assign aes_ready = aes_valid && (stub_cnt == stub_delay);
   assign aes_rd = stub_f(aes_sub, aes_enc, aes_rot, aes_rs1, aes_rs2);

   always @(posedge g_clk or posedge g_reset) begin
      if (g_reset) stub_cnt <= 0;
      else if (aes_ready) stub_cnt <= 0;
      else if (aes_valid) stub_cnt <= stub_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   always @(negedge g_clk) begin
      if (!g_reset && ((rsp_valid & rsp_ready) != 2'b00)) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual=%b required=none",
                     rsp_valid);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rsp_owner", 32'(rsp_valid), 32'(1) << e.idx);
            check("rsp_rd", rsp_rd, e.rd);
         end
      end
   end

   task automatic set_req(input int i, input logic s, input logic e,
                          input logic r, input logic [31:0] a,
                          input logic [31:0] b);
      req_sub[i] = s;
      req_enc[i] = e;
      req_rot[i] = r;
      req_rs1[32*i +: 32] = a;
      req_rs2[32*i +: 32] = b;
   endtask

   task automatic push(input int i, input logic [31:0] rd);
      exp_t e;
      e.idx = i;
      e.rd = rd;
      sb_q.push_back(e);
   endtask

   // which: 0/1 = req_ready bit, 2/3 = rsp_valid bit
   task automatic wait_for(input int which, input string name);
      int c = 0;
      bit hit = 1'b0;
      while (!hit && c < 40) begin
         @(negedge g_clk);
         c++;
         case (which)
            0: hit = req_ready[0];
            1: hit = req_ready[1];
            2: hit = rsp_valid[0];
            default: hit = rsp_valid[1];
         endcase
      end
      if (!hit) timeout(name);
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      @(negedge g_clk);
      while ((busy || sb_q.size() != 0) && c < 50) begin
         @(negedge g_clk);
         c++;
      end
      if (c >= 50) timeout(name);
   endtask

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [31:0] exp_crd [4] = '{32'h33330002, 32'hF4,
                                32'h33330002, 32'hF4};

   initial begin
      int n;
      int cyc;

      // reset state
      @(negedge g_clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_aes_valid", 32'(aes_valid), 32'd0);
      check("rst_aes_rs1", aes_rs1, 32'd0);
      step();
      g_reset = 1'b0;

      // single request, zero-latency unit
      step();
      set_req(0, 1'b1, 1'b1, 1'b0, 32'h53, 32'h0);
      req_valid = 2'b01;
      @(negedge g_clk);
      check("t1_req_ready", 32'(req_ready), 32'h1);
      push(0, 32'hED);
      step();
      req_valid = 2'b00;
      @(negedge g_clk);
      check("t1_aes_valid", 32'(aes_valid), 32'd1);
      check("t1_aes_rs1", aes_rs1, 32'h53);
      check("t1_aes_subenc", 32'({aes_sub, aes_enc, aes_rot}), 32'h6);
      @(negedge g_clk);
      check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      check("t1_rsp_rd", rsp_rd, 32'hED);
      @(negedge g_clk);
      check("t1_idle", 32'(busy), 32'd0);

      // contention from reset: grants 0,1,0,1
      step();
      g_reset = 1'b1;
      set_req(0, 1'b0, 1'b1, 1'b0, 32'h11110000, 32'h00002222);
      set_req(1, 1'b1, 1'b0, 1'b1, 32'h000000F0, 32'h00010000);
      req_valid = 2'b11;
      step();
      g_reset = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 4 && cyc < 60) begin
         @(negedge g_clk);
         cyc++;
         if (req_ready != 2'b00) begin
            check("cont_gnt", 32'(req_ready), 32'(exp_gnt[n]));
            push(n % 2, exp_crd[n]);
            n++;
            if (n == 4) begin
               step();
               req_valid = 2'b00;
            end
         end
      end
      if (n < 4) timeout("cont_grants");
      wait_idle("cont_idle");

      // slow unit: operands stable for 5 cycles
      step();
      stub_delay = 5;
      set_req(1, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 32'h12345678);
      req_valid = 2'b10;
      wait_for(1, "slow_accept");
      push(1, 32'hF3DDB790);
      step();
      req_valid = 2'b00;
      for (int k = 0; k < 5; k++) begin
         @(negedge g_clk);
         check("slow_valid", 32'(aes_valid), 32'd1);
         check("slow_ready", 32'(aes_ready), 32'd0);
         check("slow_rs1", aes_rs1, 32'hA5A5A5A5);
         check("slow_rs2", aes_rs2, 32'h12345678);
         check("slow_ctl", 32'({aes_sub, aes_enc, aes_rot}), 32'h1);
      end
      @(negedge g_clk);
      check("slow_done", 32'(aes_ready), 32'd1);
      wait_idle("slow_idle");

      // back-pressure on requester 1; rsp_ready[0] must be ignored
      step();
      stub_delay = 0;
      rsp_ready = 2'b01;
      set_req(1, 1'b1, 1'b0, 1'b0, 32'h0000FFFF, 32'hFFFF0000);
      req_valid = 2'b10;
      wait_for(1, "bp_accept");
      push(1, 32'h4);
      step();
      set_req(0, 1'b1, 1'b1, 1'b0, 32'h53, 32'h0);
      req_valid = 2'b01;
      wait_for(3, "bp_rsp");
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge g_clk);
         check("bp_rsp_valid", 32'(rsp_valid), 32'h2);
         check("bp_rsp_rd", rsp_rd, 32'h4);
         check("bp_busy", 32'(busy), 32'd1);
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      step();
      rsp_ready = 2'b11;
      wait_for(0, "bp_next_accept");
      push(0, 32'hED);
      step();
      req_valid = 2'b00;
      wait_idle("bp_idle");

      // flush during a 3-cycle unit operation
      step();
      stub_delay = 3;
      set_req(0, 1'b0, 1'b0, 1'b0, 32'h12, 32'h34);
      req_valid = 2'b01;
      wait_for(0, "fl_accept");
      step();
      req_valid = 2'b00;
      flush = 1'b1;
      @(negedge g_clk);
      check("fl_valid0", 32'(aes_valid), 32'd1);
      check("fl_rsp0", 32'(rsp_valid), 32'd0);
      step();
      flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge g_clk);
         check("fl_valid", 32'(aes_valid), 32'd1);
         check("fl_wait", 32'(aes_ready), 32'd0);
      end
      @(negedge g_clk);
      check("fl_done", 32'({aes_valid, aes_ready}), 32'h3);
      @(negedge g_clk);
      check("fl_busy", 32'(busy), 32'd0);
      check("fl_rsp", 32'(rsp_valid), 32'd0);
      check("fl_aes_valid", 32'(aes_valid), 32'd0);

      // async reset in RESP; pointer must return to 0
      step();
      stub_delay = 0;
      rsp_ready = 2'b00;
      set_req(0, 1'b1, 1'b1, 1'b0, 32'h53, 32'h0);
      req_valid = 2'b01;
      wait_for(0, "rr_accept");
      step();
      req_valid = 2'b00;
      wait_for(2, "rr_resp");
      #1;
      g_reset = 1'b1;
      #1;
      check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rr_aes_valid", 32'(aes_valid), 32'd0);
      check("rr_busy", 32'(busy), 32'd0);
      check("rr_rs1", aes_rs1, 32'd0);
      step();
      g_reset = 1'b0;
      rsp_ready = 2'b11;
      set_req(1, 1'b1, 1'b0, 1'b1, 32'h000000F0, 32'h00010000);
      req_valid = 2'b11;
      @(negedge g_clk);
      check("rr_first_gnt", 32'(req_ready), 32'h1);
      push(0, 32'hED);
      step();
      req_valid = 2'b00;
      wait_idle("rr_idle");

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_v2_arb.md
Name: aes_v2_arb

Overview:
- Round-robin arbiter and sequencer that shares one aes_v2 instance (SubBytes/MixColumns step unit) between NREQ independent requesters, for example a scalar issue port and a key-schedule engine.
- Accepts one request at a time and latches its operands.
- Holds the aes_v2 valid/operand bus stable until aes_v2 signals ready.
- Captures the result and returns it to the originating requester over a valid/ready response channel.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IW, 2, requester index width; must be at least clog2(NREQ).

Ports:
- g_clk  in  1  clock; all state rises on posedge.
- g_reset  in  1  reset, asynchronous, active-high.
- flush  in  1  discard the in-flight operation's response.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept.
- req_sub  in  NREQ  per-requester op select: 1 = sub, 0 = mix.
- req_enc  in  NREQ  per-requester direction: 1 = encrypt, 0 = decrypt.
- req_rot  in  NREQ  per-requester rotate flag (sub only).
- req_rs1  in  32*NREQ  packed rs1 operands; requester i occupies bits [32i+31:32i].
- req_rs2  in  32*NREQ  packed rs2 operands, same packing.
- rsp_valid  out  NREQ  per-requester response valid.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_rd  out  32  result, shared by all requesters; qualified by rsp_valid.
- aes_valid  out  1  drives aes_v2 valid.
- aes_sub  out  1  drives aes_v2 sub.
- aes_enc  out  1  drives aes_v2 enc.
- aes_rot  out  1  drives aes_v2 rot.
- aes_rs1  out  32  drives aes_v2 rs1.
- aes_rs2  out  32  drives aes_v2 rs2.
- aes_ready  in  1  from aes_v2 ready.
- aes_rd  in  32  from aes_v2 rd.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state = IDLE, round-robin pointer = 0, owner = 0, all operand and result registers = 0. req_ready, rsp_valid, aes_valid and busy are all 0.
- States:
  - IDLE: arbitrate among requesters with req_valid set.
  - ISSUE: aes_valid = 1; operand registers drive the aes_* bus.
  - RESP: rsp_valid[owner] = 1.
- Arbitration (IDLE only):
  - Grant goes to the first i with req_valid[i] set, searching from the pointer upward and wrapping modulo NREQ.
  - req_ready[grant] = 1 combinationally in IDLE; every other req_ready bit is 0.
  - On acceptance: latch sub/enc/rot/rs1/rs2 and owner = grant; pointer = (grant+1) mod NREQ; next state is ISSUE.
- ISSUE:
  - aes_valid and all aes_* operand outputs stay constant until aes_ready.
  - On aes_ready: latch aes_rd into the result register.
  - Next state is RESP, or IDLE if the operation was flushed.
- RESP:
  - rsp_rd = result register.
  - On rsp_ready[owner], the next state is IDLE.
  - rsp_ready on non-owner bits is ignored.
- Latency:
  - Request accepted in cycle N; aes_valid high from N+1.
  - If aes_ready is asserted in N+1, rsp_valid is high in N+2.
  - No new request is accepted until the cycle after the response handshake.
  - Sustained throughput is at most 1 operation per 3 cycles.
- Flush:
  - In IDLE or RESP: return to IDLE next cycle; a pending response is dropped.
  - In ISSUE: aes_valid is not dropped, because aes_v2 has no abort. A sticky flushed flag is set; on aes_ready the result is discarded and the next state is IDLE.
  - flush coincident with aes_ready discards that result.
- Simultaneous requests: exactly one bit of req_ready is set per cycle.
- A requester that deasserts req_valid before its handshake loses nothing; the arbiter holds no state for it.
- Reset mid-operation: asynchronous return to reset values. aes_v2 shares g_reset, so no stale ready is carried over.
- aes_ready while not in ISSUE is ignored.

Decomposition:
- Shared package aes_v2_pkg holds:
  - state encoding localparams: ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RESP = 2'd2;
  - the operand record width, 67 bits: sub, enc, rot, rs1, rs2.
- One sub-module, aes_v2_rr_pick: combinational round-robin picker taking req_valid and the pointer and producing a one-hot grant plus an index.
- The top level holds the FSM, operand, result and flushed registers.

Test Plan:
- Single request: requester 0 issues sub=1, enc=1, rs1=0x00000053, rs2=0. Require aes_valid at N+1 holding rs1=0x53 until aes_ready; rsp_valid[0] at N+2 with rsp_rd equal to aes_rd (0x000000ED, from the stub).
- Contention: both req_valid held high from reset for 4 operations. Require grants in the order 0,1,0,1; the pointer alternates.
- Slow unit: a stub delays aes_ready by 5 cycles while a bench monitor checks operands every cycle. Require aes_rs1/aes_rs2/aes_sub/aes_enc/aes_rot to stay stable and aes_valid to stay high for all 5 cycles.
- Back-pressure: rsp_ready[1] withheld for 4 cycles. Require rsp_valid[1] and rsp_rd to hold, busy = 1, and req_ready = 0 throughout.
- Flush in ISSUE: flush pulsed while the stub delays aes_ready by 3 cycles. Require aes_valid to stay high until aes_ready, no rsp_valid pulse, and a return to IDLE with busy = 0 one cycle after aes_ready.
- Async reset asserted during RESP: require rsp_valid, aes_valid and busy = 0 immediately (before the next edge), and the pointer = 0 so requester 0 is granted first after release.
